// File: rtl/reg_trace_rules_if.sv
// rtl/reg_trace_rules_if.sv - register front-end bus between the host decoder and reg_trace_rules
interface reg_trace_rules_if #(
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               read_data;
  logic [7:0]               write_data;
  logic                     reg_read;
  logic                     reg_write;
  logic                     reg_addrvalid;
  logic                     selected;

  modport master (
    output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    input  read_data, selected
  );

  modport slave (
    input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    output read_data, selected
  );
endinterface

// File: rtl/reg_trace_rules.sv
// rtl/reg_trace_rules.sv - trace matcher rule registers with shadow/active commit and hit counters
module reg_trace_rules #(
  parameter int         pMATCH_RULES  = 8,
  parameter int         pBUFFER_SIZE  = 64,
  parameter int         pBYTECNT_SIZE = 7,
  parameter int         pCOUNT_WIDTH  = 16,
  parameter logic [1:0] pSELECT       = 2'b01
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_i,
  reg_trace_rules_if.slave                     bus,
  input  logic                                 I_commit_ok,
  input  logic [pMATCH_RULES-1:0]              I_match_hit,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_pattern,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_mask,
  output logic [pMATCH_RULES-1:0]              O_pattern_enable,
  output logic [pMATCH_RULES-1:0]              O_pattern_trig_enable,
  output logic                                 O_match_hold,
  output logic                                 O_update
);
  localparam int PB = pBUFFER_SIZE / 8;
  localparam int CB = pCOUNT_WIDTH / 8;
  localparam int IW = (pMATCH_RULES > 1) ? $clog2(pMATCH_RULES) : 1;
  localparam logic [pCOUNT_WIDTH-1:0] SAT_M1 = {{(pCOUNT_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COPY} state_t;

  logic [pBUFFER_SIZE-1:0] sh_pat [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0] sh_mask [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0] act_pat [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0] act_mask [pMATCH_RULES];
  logic [pCOUNT_WIDTH-1:0] cnt [pMATCH_RULES];
  logic [pMATCH_RULES-1:0] sh_en, sh_ten, act_en, act_ten, hit_clr;
  logic [3:0]              rule_sel;
  logic                    commit_pending, sat, write_drop, update_q;
  logic [7:0]              rd_q, rd_d;
  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    copy_en, copy_last, clr_pending;

  logic [5:0]               reg_a;
  logic [pBYTECNT_SIZE-1:0] bc;
  logic                     wr, byte0, copying;

  assign reg_a        = bus.reg_address[5:0];
  assign bc           = bus.reg_bytecnt;
  assign bus.selected = bus.reg_addrvalid & (bus.reg_address[7:6] == pSELECT);
  assign wr           = bus.selected & bus.reg_write;
  assign byte0        = (bc == '0);
  assign copying      = (state_q == S_COPY);
  assign bus.read_data = rd_q;
  assign O_match_hold = copying;
  assign O_update     = update_q;
  assign O_pattern_enable      = act_en;
  assign O_pattern_trig_enable = act_ten;

  for (genvar g = 0; g < pMATCH_RULES; g++) begin : g_flat
    assign O_trace_pattern[g*pBUFFER_SIZE +: pBUFFER_SIZE] = act_pat[g];
    assign O_trace_mask[g*pBUFFER_SIZE +: pBUFFER_SIZE]    = act_mask[g];
  end

  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Stalled COPY cycles hold idx so the matcher can run between rule copies.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    copy_en     = 1'b0;
    copy_last   = 1'b0;
    clr_pending = 1'b0;
    case (state_q)
      S_IDLE: if (commit_pending) state_d = S_WAIT;
      S_WAIT: if (I_commit_ok) begin
        state_d     = S_COPY;
        idx_d       = '0;
        clr_pending = 1'b1;
      end
      S_COPY: if (I_commit_ok) begin
        copy_en = 1'b1;
        if (idx_q == IW'(pMATCH_RULES - 1)) begin
          copy_last = 1'b1;
          state_d   = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < pMATCH_RULES; r++)
      hit_clr[r] = wr && (reg_a == 6'h08) && (bc == pBYTECNT_SIZE'(r / 8)) && bus.write_data[r % 8];
  end

  always_comb begin
    rd_d = '0;
    case (reg_a)
      6'h00: if (byte0) rd_d = {4'b0, rule_sel};
      6'h01, 6'h02, 6'h07: begin
        for (int r = 0; r < pMATCH_RULES; r++) begin
          for (int b = 0; b < PB; b++)
            if (rule_sel == 4'(r) && bc == pBYTECNT_SIZE'(b) && reg_a != 6'h07)
              rd_d = (reg_a == 6'h01) ? sh_pat[r][b*8 +: 8] : sh_mask[r][b*8 +: 8];
          for (int b = 0; b < CB; b++)
            if (rule_sel == 4'(r) && bc == pBYTECNT_SIZE'(b) && reg_a == 6'h07)
              rd_d = cnt[r][b*8 +: 8];
        end
      end
      6'h03, 6'h04: begin
        for (int i = 0; i < pMATCH_RULES; i++)
          if (bc == pBYTECNT_SIZE'(i / 8))
            rd_d[i % 8] = (reg_a == 6'h03) ? sh_en[i] : sh_ten[i];
      end
      6'h06: if (byte0) rd_d = {4'b0, write_drop, sat, copying, commit_pending};
      6'h0A: if (byte0) rd_d = 8'(pMATCH_RULES);
      6'h0B: if (byte0) rd_d = 8'h02;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      for (int r = 0; r < pMATCH_RULES; r++) begin
        sh_pat[r]   <= '0;
        sh_mask[r]  <= '1;
        act_pat[r]  <= '0;
        act_mask[r] <= '1;
        cnt[r]      <= '0;
      end
      sh_en          <= '0;
      sh_ten         <= '0;
      act_en         <= '0;
      act_ten        <= '0;
      rule_sel       <= '0;
      commit_pending <= 1'b0;
      sat            <= 1'b0;
      write_drop     <= 1'b0;
      update_q       <= 1'b0;
      rd_q           <= '0;
    end else begin
      update_q       <= copy_last;
      rd_q           <= (bus.selected && bus.reg_read) ? rd_d : 8'h00;
      commit_pending <= (commit_pending & ~clr_pending) | (wr && reg_a == 6'h05);

      for (int r = 0; r < pMATCH_RULES; r++) begin
        if (copy_en && idx_q == IW'(r)) begin
          act_pat[r]  <= sh_pat[r];
          act_mask[r] <= sh_mask[r];
        end
      end
      if (copy_last) begin
        act_en  <= sh_en;
        act_ten <= sh_ten;
      end

      if (wr && reg_a == 6'h00 && byte0) rule_sel <= bus.write_data[3:0];
      if (wr && copying && reg_a >= 6'h01 && reg_a <= 6'h04) write_drop <= 1'b1;
      if (wr && reg_a == 6'h09) begin
        sat        <= 1'b0;
        write_drop <= 1'b0;
      end

      for (int r = 0; r < pMATCH_RULES; r++)
        for (int b = 0; b < PB; b++)
          if (wr && !copying && rule_sel == 4'(r) && bc == pBYTECNT_SIZE'(b)) begin
            if (reg_a == 6'h01) sh_pat[r][b*8 +: 8]  <= bus.write_data;
            if (reg_a == 6'h02) sh_mask[r][b*8 +: 8] <= bus.write_data;
          end
      for (int i = 0; i < pMATCH_RULES; i++)
        if (wr && !copying && bc == pBYTECNT_SIZE'(i / 8)) begin
          if (reg_a == 6'h03) sh_en[i]  <= bus.write_data[i % 8];
          if (reg_a == 6'h04) sh_ten[i] <= bus.write_data[i % 8];
        end

      // Placed after STATUS_CLEAR so a same-cycle saturation is not lost.
      for (int r = 0; r < pMATCH_RULES; r++) begin
        if (hit_clr[r]) begin
          cnt[r] <= '0;
        end else if (I_match_hit[r] && cnt[r] != '1) begin
          cnt[r] <= cnt[r] + 1'b1;
          if (cnt[r] == SAT_M1) sat <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_trace_rules.sv
// tb/tb_reg_trace_rules.sv - self-checking bench for reg_trace_rules
`timescale 1ns/1ps
module tb_reg_trace_rules;
  localparam int R = 8, W = 64, BCW = 7, CW = 16;

  logic usb_clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 usb_clk = ~usb_clk;

  reg_trace_rules_if #(.pBYTECNT_SIZE(BCW)) bus();

  logic           I_commit_ok;
  logic [R-1:0]   I_match_hit;
  logic [R*W-1:0] O_trace_pattern, O_trace_mask;
  logic [R-1:0]   O_pattern_enable, O_pattern_trig_enable;
  logic           O_match_hold, O_update;

  reg_trace_rules #(.pMATCH_RULES(R), .pBUFFER_SIZE(W), .pBYTECNT_SIZE(BCW),
                    .pCOUNT_WIDTH(CW), .pSELECT(2'b01)) dut (
    .usb_clk(usb_clk), .reset_i(reset_i), .bus(bus),
    .I_commit_ok(I_commit_ok), .I_match_hit(I_match_hit),
    .O_trace_pattern(O_trace_pattern), .O_trace_mask(O_trace_mask),
    .O_pattern_enable(O_pattern_enable), .O_pattern_trig_enable(O_pattern_trig_enable),
    .O_match_hold(O_match_hold), .O_update(O_update)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [R*W-1:0] act, input logic [R*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input int bc, input logic [7:0] d);
    @(negedge usb_clk);
    bus.reg_addrvalid = 1'b1;
    bus.reg_address   = {2'b01, a};
    bus.reg_bytecnt   = BCW'(bc);
    bus.write_data    = d;
    bus.reg_write     = 1'b1;
    @(negedge usb_clk);
    bus.reg_write     = 1'b0;
    bus.reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input int bc, output logic [7:0] d);
    @(negedge usb_clk);
    bus.reg_addrvalid = 1'b1;
    bus.reg_address   = {2'b01, a};
    bus.reg_bytecnt   = BCW'(bc);
    bus.reg_read      = 1'b1;
    @(negedge usb_clk);
    d = bus.read_data;
    bus.reg_read      = 1'b0;
    bus.reg_addrvalid = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input int bc, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, bc, d);
    chk(name, {{(R*W-8){1'b0}}, d}, {{(R*W-8){1'b0}}, exp});
  endtask

  typedef struct {
    logic       is_wr;
    logic [5:0] a;
    int         bc;
    logic [7:0] d;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];
  logic [R*W-1:0] exp_pat;
  logic [R*W-1:0] ones;
  int hc, uc, en_cnt, k;
  logic seen, done, bad;

  initial begin
    ones = '1;
    bus.reg_address = '0; bus.reg_bytecnt = '0; bus.write_data = '0;
    bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
    I_commit_ok = 1'b1; I_match_hit = '0;
    repeat (3) @(negedge usb_clk);
    reset_i = 1'b0;

    chk("rst_pattern", O_trace_pattern, '0);
    chk("rst_mask", O_trace_mask, ones);
    chk("rst_hold_update", {O_match_hold, O_update}, '0);
    chk("rst_read_data", {{(R*W-8){1'b0}}, bus.read_data}, '0);

    tbl.push_back('{1'b0, 6'h0A, 0, 8'h00, 8'h08, "num_rules"});
    tbl.push_back('{1'b0, 6'h0B, 0, 8'h00, 8'h02, "name_rev"});
    tbl.push_back('{1'b0, 6'h00, 0, 8'h00, 8'h00, "rule_sel_rst"});
    tbl.push_back('{1'b0, 6'h06, 0, 8'h00, 8'h00, "status_rst"});
    tbl.push_back('{1'b0, 6'h0A, 1, 8'h00, 8'h00, "num_rules_b1"});
    tbl.push_back('{1'b1, 6'h00, 0, 8'h03, 8'h00, ""});
    tbl.push_back('{1'b0, 6'h00, 0, 8'h00, 8'h03, "rule_sel"});
    for (int b = 0; b < 8; b++)
      tbl.push_back('{1'b1, 6'h01, b, 8'((b + 1) * 8'h11), 8'h00, ""});
    tbl.push_back('{1'b0, 6'h01, 0, 8'h00, 8'h11, "pat_b0"});
    tbl.push_back('{1'b0, 6'h01, 7, 8'h00, 8'h88, "pat_b7"});
    tbl.push_back('{1'b0, 6'h01, 8, 8'h00, 8'h00, "pat_b8_beyond"});
    tbl.push_back('{1'b0, 6'h02, 3, 8'h00, 8'hFF, "mask_rst"});
    tbl.push_back('{1'b1, 6'h03, 0, 8'hA5, 8'h00, ""});
    tbl.push_back('{1'b0, 6'h03, 0, 8'h00, 8'hA5, "en_b0"});
    tbl.push_back('{1'b0, 6'h03, 1, 8'h00, 8'h00, "en_b1"});
    tbl.push_back('{1'b1, 6'h04, 0, 8'h3C, 8'h00, ""});
    tbl.push_back('{1'b0, 6'h04, 0, 8'h00, 8'h3C, "ten_b0"});
    tbl.push_back('{1'b0, 6'h20, 0, 8'h00, 8'h00, "unmapped"});
    tbl.push_back('{1'b1, 6'h00, 0, 8'h09, 8'h00, ""});
    tbl.push_back('{1'b1, 6'h01, 0, 8'h55, 8'h00, ""});
    tbl.push_back('{1'b0, 6'h01, 0, 8'h00, 8'h00, "pat_badsel"});
    tbl.push_back('{1'b0, 6'h07, 0, 8'h00, 8'h00, "hit_badsel"});
    tbl.push_back('{1'b1, 6'h00, 0, 8'h01, 8'h00, ""});
    tbl.push_back('{1'b0, 6'h01, 0, 8'h00, 8'h00, "pat_r1_untouched"});
    tbl.push_back('{1'b1, 6'h00, 0, 8'h03, 8'h00, ""});

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) wr(tbl[i].a, tbl[i].bc, tbl[i].d);
      else rd_chk(tbl[i].name, tbl[i].a, tbl[i].bc, tbl[i].exp);
    end

    // Commit with the matcher idle
    wr(6'h05, 0, 8'h01);
    hc = 0; uc = 0;
    repeat (30) begin
      @(negedge usb_clk);
      if (O_match_hold) hc++;
      if (O_update) uc++;
    end
    chk("commit_hold_cycles", R*W'(hc), R*W'(8));
    chk("commit_update_pulses", R*W'(uc), R*W'(1));
    exp_pat = '0;
    exp_pat[3*W +: W] = 64'h8877665544332211;
    chk("commit_pattern", O_trace_pattern, exp_pat);
    chk("commit_mask", O_trace_mask, ones);
    chk("commit_enables", {O_pattern_trig_enable, O_pattern_enable}, {8'h3C, 8'hA5});

    // Commit held off by the matcher
    I_commit_ok = 1'b0;
    wr(6'h01, 0, 8'h99);
    wr(6'h05, 0, 8'h01);
    bad = 1'b0;
    repeat (20) begin
      @(negedge usb_clk);
      if (O_match_hold || O_update) bad = 1'b1;
    end
    chk("stall_no_hold", R*W'(bad), '0);
    chk("stall_pattern", O_trace_pattern, exp_pat);
    rd_chk("stall_status", 6'h06, 0, 8'h01);
    I_commit_ok = 1'b1;
    hc = 0; uc = 0;
    repeat (30) begin
      @(negedge usb_clk);
      if (O_match_hold) hc++;
      if (O_update) uc++;
    end
    chk("release_hold_cycles", R*W'(hc), R*W'(8));
    chk("release_update", R*W'(uc), R*W'(1));
    exp_pat[3*W +: W] = 64'h8877665544332299;
    chk("release_pattern", O_trace_pattern, exp_pat);

    // Toggle I_commit_ok mid-copy
    wr(6'h05, 0, 8'h01);
    seen = 1'b0; done = 1'b0; en_cnt = 0; uc = 0; k = 0;
    while (!done && k < 200) begin
      @(negedge usb_clk);
      k++;
      if (O_update) uc++;
      if (O_match_hold) begin
        seen = 1'b1;
        I_commit_ok = (k % 3 != 1);
        if (I_commit_ok) en_cnt++;
      end else begin
        if (seen) done = 1'b1;
        I_commit_ok = 1'b1;
      end
    end
    I_commit_ok = 1'b1;
    chk("toggle_finished", R*W'(done), R*W'(1));
    chk("toggle_enabled_cycles", R*W'(en_cnt), R*W'(8));
    chk("toggle_update", R*W'(uc), R*W'(1));

    // Write during copy is dropped
    wr(6'h05, 0, 8'h01);
    k = 0;
    while (!O_match_hold && k < 20) begin @(negedge usb_clk); k++; end
    I_commit_ok = 1'b0;
    wr(6'h01, 0, 8'h77);
    rd_chk("drop_status", 6'h06, 0, 8'h0A);
    I_commit_ok = 1'b1;
    k = 0;
    while (O_match_hold && k < 20) begin @(negedge usb_clk); k++; end
    chk("drop_copy_done", R*W'(O_match_hold), '0);
    rd_chk("drop_shadow", 6'h01, 0, 8'h99);
    wr(6'h09, 0, 8'h00);
    rd_chk("status_clear", 6'h06, 0, 8'h00);

    // Hit counters
    wr(6'h00, 0, 8'h05);
    @(negedge usb_clk);
    I_match_hit = 8'h20;
    repeat (3) @(negedge usb_clk);
    I_match_hit = '0;
    rd_chk("hit5_count", 6'h07, 0, 8'h03);
    rd_chk("hit5_no_sat", 6'h06, 0, 8'h00);
    wr(6'h00, 0, 8'h02);
    @(negedge usb_clk);
    I_match_hit = 8'h04;
    repeat (70000) @(negedge usb_clk);
    I_match_hit = '0;
    rd_chk("hit2_b0", 6'h07, 0, 8'hFF);
    rd_chk("hit2_b1", 6'h07, 1, 8'hFF);
    rd_chk("hit2_b2_beyond", 6'h07, 2, 8'h00);
    rd_chk("sat_status", 6'h06, 0, 8'h04);
    @(negedge usb_clk);
    bus.reg_addrvalid = 1'b1;
    bus.reg_address   = {2'b01, 6'h08};
    bus.reg_bytecnt   = '0;
    bus.write_data    = 8'h04;
    bus.reg_write     = 1'b1;
    I_match_hit       = 8'h04;
    @(negedge usb_clk);
    bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0; I_match_hit = '0;
    rd_chk("clear_wins_b0", 6'h07, 0, 8'h00);
    rd_chk("clear_wins_b1", 6'h07, 1, 8'h00);
    wr(6'h00, 0, 8'h05);
    rd_chk("hit5_kept", 6'h07, 0, 8'h03);

    // Reset in the middle of a copy
    wr(6'h05, 0, 8'h01);
    k = 0;
    while (!O_match_hold && k < 20) begin @(negedge usb_clk); k++; end
    repeat (4) @(negedge usb_clk);
    chk("pre_reset_copying", R*W'(O_match_hold), R*W'(1));
    reset_i = 1'b1;
    @(negedge usb_clk);
    chk("midcopy_pattern", O_trace_pattern, '0);
    chk("midcopy_mask", O_trace_mask, ones);
    chk("midcopy_enables", {O_pattern_trig_enable, O_pattern_enable, O_match_hold, O_update}, '0);
    reset_i = 1'b0;
    uc = 0; hc = 0;
    repeat (15) begin
      @(negedge usb_clk);
      if (O_update) uc++;
      if (O_match_hold) hc++;
    end
    chk("midcopy_no_update", R*W'(uc), '0);
    chk("midcopy_no_hold", R*W'(hc), '0);
    rd_chk("midcopy_status", 6'h06, 0, 8'h00);
    rd_chk("midcopy_rule_sel", 6'h00, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
